// File: rtl/dual_rail_countdown_pkg.sv
// dr_pkg: types and helpers shared by the dual-rail countdown sequencer.
//   state_t    - sequencer states
//   dr_pair_t  - one dual-rail pair {t, f}
//   dr_word_t  - four pairs; index 3 is pair E1 (operand MSB), index 0 is E4
//   DR_NULL / DR_DATA0 / DR_DATA1 - legal pair codes; (1,1) is illegal
//   dr_encode  - 4-bit value -> four DATA pairs
package dr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE_DATA,
    DRIVE_NULL,
    DONE
  } state_t;

  typedef struct packed {
    logic t;
    logic f;
  } dr_pair_t;

  typedef dr_pair_t [3:0] dr_word_t;

  localparam dr_pair_t DR_NULL  = 2'b00;
  localparam dr_pair_t DR_DATA0 = 2'b01;
  localparam dr_pair_t DR_DATA1 = 2'b10;

  function automatic dr_word_t dr_encode(input logic [3:0] v);
    dr_word_t w;
    for (int unsigned i = 0; i < 4; i++) begin
      w[i] = v[i] ? DR_DATA1 : DR_DATA0;
    end
    return w;
  endfunction

endpackage

// File: rtl/dual_rail_countdown_if.sv
// dual_rail_countdown_if: start/done handshake between synchronous logic and
// the dual-rail countdown sequencer.
//   start    - begin a countdown (honoured only while the sequencer is idle)
//   load_val - countdown start value, sampled when start is accepted
//   busy     - countdown in progress
//   done     - one-cycle pulse on detector-reported zero
//   err      - sticky timeout / check-failure flag
//   steps    - decrements performed in the current/last countdown
// master: the controlling logic; slave: the sequencer.
interface dual_rail_countdown_if;

  logic       start;
  logic [3:0] load_val;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] steps;

  modport master (
    output start, load_val,
    input  busy, done, err, steps
  );

  modport slave (
    input  start, load_val,
    output busy, done, err, steps
  );

endinterface

// File: rtl/dual_rail_countdown_completion_filter.sv
// dr_completion_filter: registers the detector's dual-rail result and
// qualifies it.
//   clk, rst         - clock, synchronous active-high reset
//   in_t, in_f       - raw dual-rail pair from the detector
//   is_null, is_data - registered pair has held that complete code for
//                      SETTLE consecutive cycles
//   is_illegal       - registered pair is (1,1) (not qualified; it never
//                      counts as settled)
//   data_val         - true rail of the registered pair
module dr_completion_filter
  import dr_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in_t,
  input  logic in_f,
  output logic is_null,
  output logic is_data,
  output logic is_illegal,
  output logic data_val
);

  localparam int unsigned SW = $clog2(SETTLE + 1);
  localparam logic [SW-1:0] SMAX = SW'(SETTLE);

  dr_pair_t      in_p;
  dr_pair_t      zr;
  logic [SW-1:0] sc;

  assign in_p = {in_t, in_f};

  // sc counts the cycles (saturating at SETTLE) that zr has held its current
  // complete value; a change or an illegal code restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      zr <= DR_NULL;
      sc <= '0;
    end else begin
      zr <= in_p;
      if (in_p == 2'b11) begin
        sc <= '0;
      end else if (in_p == zr) begin
        if (sc != SMAX) sc <= sc + SW'(1);
      end else begin
        sc <= SW'(1);
      end
    end
  end

  assign is_null    = (zr == DR_NULL) && (sc == SMAX);
  assign is_data    = ((zr == DR_DATA0) || (zr == DR_DATA1)) && (sc == SMAX);
  assign is_illegal = (zr == 2'b11);
  assign data_val   = zr.t;

endmodule

// File: rtl/dual_rail_countdown.sv
// dual_rail_countdown: clocked sequencer for a 4-input dual-rail zero
// detector. Loads a value, presents it as alternating DATA/NULL wavefronts,
// and decrements on each "non-zero" answer until the detector reports zero.
//   clk, rst            - clock, synchronous active-high reset
//   ctl (slave)         - start/load_val in; busy/done/err/steps out
//   E1_t/E1_f..E4_t/E4_f- registered dual-rail operand (E1 = bit 3)
//   zero_t, zero_f      - dual-rail detector result
// Optional build macro DR_CHECK_EN: abort with err on a (1,1) result or on a
// result that disagrees with the loaded count; otherwise results are trusted.
module dual_rail_countdown
  import dr_pkg::*;
#(
  parameter int unsigned SETTLE         = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  dual_rail_countdown_if.slave  ctl,
  output logic                  E1_t,
  output logic                  E1_f,
  output logic                  E2_t,
  output logic                  E2_f,
  output logic                  E3_t,
  output logic                  E3_f,
  output logic                  E4_t,
  output logic                  E4_f,
  input  logic                  zero_t,
  input  logic                  zero_f
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  state_t        state, state_d;
  logic [3:0]    cnt, cnt_d;
  logic [3:0]    steps_q, steps_d;
  logic          err_q, err_d;
  logic [TW-1:0] timer;
  dr_word_t      e_q;
  logic          busy_q;
  logic          done_q;

  logic f_null, f_data, f_illegal, f_val;

  dr_completion_filter #(
    .SETTLE(SETTLE)
  ) u_filter (
    .clk        (clk),
    .rst        (rst),
    .in_t       (zero_t),
    .in_f       (zero_f),
    .is_null    (f_null),
    .is_data    (f_data),
    .is_illegal (f_illegal),
    .data_val   (f_val)
  );

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    steps_d = steps_q;
    err_d   = err_q;
    case (state)
      IDLE: begin
        if (ctl.start) begin
          cnt_d   = ctl.load_val;
          steps_d = '0;
          err_d   = 1'b0;
          state_d = DRIVE_DATA;
        end
      end
      DRIVE_DATA: begin
        if (timer == TMAX) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
`ifdef DR_CHECK_EN
        else if (f_illegal) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (f_data) begin
          if (f_val != (cnt == 4'd0)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (f_val) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt - 4'd1;
            steps_d = steps_q + 4'd1;
            state_d = DRIVE_NULL;
          end
        end
`else
        // (1,1) never settles, so it can only end in a timeout.
        else if (f_data && !f_illegal) begin
          if (f_val) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt - 4'd1;
            steps_d = steps_q + 4'd1;
            state_d = DRIVE_NULL;
          end
        end
`endif
      end
      DRIVE_NULL: begin
        if (timer == TMAX) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
`ifdef DR_CHECK_EN
        else if (f_illegal) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
`endif
        else if (f_null) begin
          state_d = DRIVE_DATA;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      steps_q <= '0;
      err_q   <= 1'b0;
      timer   <= '0;
      e_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      steps_q <= steps_d;
      err_q   <= err_d;
      if (state_d != state) begin
        timer <= '0;
      end else if (timer != TMAX) begin
        timer <= timer + TW'(1);
      end
      // Outputs follow the next state so phase changes show on E in the same
      // edge; the IDLE->DRIVE_DATA entry alone is held back one cycle, which
      // gives the extra first cycle between acceptance and the first DATA.
      e_q    <= (state_d == DRIVE_DATA && state != IDLE) ? dr_encode(cnt_d) : '0;
      busy_q <= (state_d == DRIVE_DATA || state_d == DRIVE_NULL) && (state != IDLE);
      done_q <= (state_d == DONE);
    end
  end

  assign E1_t = e_q[3].t;
  assign E1_f = e_q[3].f;
  assign E2_t = e_q[2].t;
  assign E2_f = e_q[2].f;
  assign E3_t = e_q[1].t;
  assign E3_f = e_q[1].f;
  assign E4_t = e_q[0].t;
  assign E4_f = e_q[0].f;

  assign ctl.busy  = busy_q;
  assign ctl.done  = done_q;
  assign ctl.err   = err_q;
  assign ctl.steps = steps_q;

endmodule

// File: tb/tb_dual_rail_countdown.sv
// Scoreboard bench for dual_rail_countdown: a behavioural detector model
// answers the E wavefronts; the driver pushes the expected outcome of each
// countdown (from the closed-form rules) and a monitor checks what appears.
module tb_dual_rail_countdown;

  localparam int unsigned SETTLE = 2;
  localparam int unsigned TMO    = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dual_rail_countdown_if ifc ();

  logic E1_t, E1_f, E2_t, E2_f, E3_t, E3_f, E4_t, E4_f;
  logic zero_t, zero_f;

  dual_rail_countdown #(
    .SETTLE         (SETTLE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ctl    (ifc.slave),
    .E1_t   (E1_t),
    .E1_f   (E1_f),
    .E2_t   (E2_t),
    .E2_f   (E2_f),
    .E3_t   (E3_t),
    .E3_f   (E3_f),
    .E4_t   (E4_t),
    .E4_f   (E4_f),
    .zero_t (zero_t),
    .zero_f (zero_f)
  );

  logic [3:0] et, ef;
  logic all_data, all_null;
  assign et = {E1_t, E2_t, E3_t, E4_t};
  assign ef = {E1_f, E2_f, E3_f, E4_f};
  assign all_data = ((et ^ ef) == 4'hF) && ((et & ef) == 4'h0);
  assign all_null = ((et | ef) == 4'h0);

  // Detector model: 0 = ideal, 1 = stuck NULL, 2 = stuck (1,1)
  int det_mode = 0;
  always_comb begin
    zero_t = 1'b0;
    zero_f = 1'b0;
    if (det_mode == 1) begin
      zero_t = 1'b0;
      zero_f = 1'b0;
    end else if (det_mode == 2) begin
      zero_t = 1'b1;
      zero_f = 1'b1;
    end else if (all_data) begin
      zero_t = (et == 4'd0);
      zero_f = (et != 4'd0);
    end
  end

  typedef struct {
    bit is_done;
    int steps;
    int lat;
    bit err;
  } exp_t;

  exp_t sb[$];
  int   wq[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   n_fin      = 0;
  int   acc_cyc    = 0;
  bit   prev_busy  = 1'b0;
  bit   prev_data  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor: samples on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      wq.delete();
      prev_busy = 1'b0;
      prev_data = 1'b0;
    end else begin
      chk("e_no_illegal_pair", int'(et & ef), 0);
      if (all_data && !prev_data) begin
        if (wq.size() == 0) chk("wave_expected", 0, 1);
        else chk("wave_value", int'(et), wq.pop_front());
      end
      if (ifc.busy && !prev_busy) begin
        acc_cyc = cyc - 1;
        chk("err_clear_on_start", int'(ifc.err), 0);
      end
      if (ifc.done || (prev_busy && !ifc.busy)) begin
        if (sb.size() == 0) begin
          chk("end_expected", 0, 1);
        end else begin
          e = sb.pop_front();
          chk("end_is_done", int'(ifc.done), int'(e.is_done));
          chk("steps", int'(ifc.steps), e.steps);
          chk("latency", cyc - acc_cyc, e.lat);
          chk("err", int'(ifc.err), int'(e.err));
          chk("e_null_at_end", int'(all_null), 1);
          chk("busy_low_at_end", int'(ifc.busy), 0);
        end
        n_fin++;
      end
      prev_busy = ifc.busy;
      prev_data = all_data;
    end
  end

  // Expected outcome from the countdown rules, independent of RTL structure.
  task automatic push_expect(input int v, input int mode);
    exp_t e;
    if (mode == 0) begin
      e.is_done = 1'b1;
      e.steps   = v;
      e.lat     = 1 + (2 * v + 1) * (SETTLE + 1);
      e.err     = 1'b0;
      for (int k = v; k >= 0; k--) wq.push_back(k);
    end else begin
      e.is_done = 1'b0;
      e.steps   = 0;
      e.lat     = TMO + 1;
      e.err     = 1'b1;
      wq.push_back(v);
    end
    sb.push_back(e);
  endtask

  task automatic run_txn(input int v, input int mode, input bit pokes);
    int target;
    int k;
    @(posedge clk) #1;
    det_mode = mode;
    push_expect(v, mode);
    target = n_fin + 1;
    ifc.load_val = 4'(v);
    ifc.start    = 1'b1;
    k = 0;
    while (!ifc.busy && k < 8) begin
      @(posedge clk) #1;
      k++;
    end
    chk("busy_rise", int'(ifc.busy), 1);
    ifc.start = 1'b0;
    k = 0;
    while (n_fin < target && k < 3000) begin
      if (pokes) begin
        ifc.start    = ifc.busy && ($urandom_range(0, 3) == 0);
        ifc.load_val = 4'($urandom);
      end
      @(posedge clk) #1;
      k++;
    end
    ifc.start = 1'b0;
    chk("txn_finished", int'(n_fin >= target), 1);
    det_mode = 0;
    repeat ($urandom_range(1, 4)) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit seen;
    ifc.start    = 1'b0;
    ifc.load_val = 4'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_e", int'({et, ef}), 0);
    chk("rst_busy", int'(ifc.busy), 0);
    chk("rst_done", int'(ifc.done), 0);
    chk("rst_err", int'(ifc.err), 0);
    chk("rst_steps", int'(ifc.steps), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run_txn(0, 0, 1'b0);
    run_txn(5, 0, 1'b0);
    run_txn(15, 0, 1'b1);
    for (int i = 0; i < 20; i++) run_txn(int'($urandom_range(0, 15)), 0, 1'b1);

    run_txn(int'($urandom_range(1, 15)), 1, 1'b1);
    run_txn(3, 0, 1'b0);

`ifdef DR_CHECK_EN
    @(posedge clk) #1;
    det_mode = 2;
    ifc.load_val = 4'd6;
    ifc.start    = 1'b1;
    @(posedge clk) #1;
    ifc.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk) #1;
      if (ifc.done) seen = 1'b1;
    end
    chk("check_illegal_err", int'(ifc.err), 1);
    chk("check_illegal_no_done", int'(seen), 0);
    chk("check_illegal_busy", int'(ifc.busy), 0);
    det_mode = 0;
    repeat (3) @(posedge clk);
`else
    run_txn(6, 2, 1'b0);
`endif

    // Reset during a NULL phase of a load_val=9 countdown.
    @(posedge clk) #1;
    push_expect(9, 0);
    ifc.load_val = 4'd9;
    ifc.start    = 1'b1;
    k = 0;
    while (!ifc.busy && k < 8) begin
      @(posedge clk) #1;
      k++;
    end
    ifc.start = 1'b0;
    seen = 1'b0;
    k = 0;
    while (!(seen && all_null && ifc.busy) && k < 200) begin
      if (all_data) seen = 1'b1;
      @(posedge clk) #1;
      k++;
    end
    chk("reached_null_phase", int'(seen && all_null && ifc.busy), 1);
    rst = 1'b1;
    @(posedge clk) #1;
    chk("midrst_e", int'({et, ef}), 0);
    chk("midrst_busy", int'(ifc.busy), 0);
    chk("midrst_done", int'(ifc.done), 0);
    chk("midrst_err", int'(ifc.err), 0);
    chk("midrst_steps", int'(ifc.steps), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    run_txn(2, 0, 1'b0);

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    chk("waves_empty", wq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
